// File: rtl/execution_dispatcher_if.sv
// Fill-report intake (valid/ready + hold) and execute-strobe output bundle of the execution dispatcher.
interface execution_dispatcher_if #(
    parameter int ID_W = 2
);
    logic            i_fill_valid;
    logic            o_fill_ready;
    logic [ID_W-1:0] i_fill_stock_id;
    logic            i_fill_side;
    logic [15:0]     i_fill_quantity;
    logic            i_hold;
    logic            o_execute_order;
    logic            o_execute_order_side;
    logic [15:0]     o_execute_order_quantity;
    logic [ID_W-1:0] o_stock_id;

    modport master (
        output i_fill_valid, i_fill_stock_id, i_fill_side, i_fill_quantity, i_hold,
        input  o_fill_ready, o_execute_order, o_execute_order_side,
               o_execute_order_quantity, o_stock_id
    );

    modport slave (
        input  i_fill_valid, i_fill_stock_id, i_fill_side, i_fill_quantity, i_hold,
        output o_fill_ready, o_execute_order, o_execute_order_side,
               o_execute_order_quantity, o_stock_id
    );
endinterface

// File: rtl/execution_dispatcher.sv
// Buffers fill reports and issues one-cycle execute strobes (1 cycle fill-to-strobe, ready = not full, i_hold stalls),
// tracking saturating signed positions per stock; define POS_LIMIT_EN to build the per-stock limit flags.
module execution_dispatcher #(
    parameter int NUM_STOCKS = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int POS_WIDTH  = 32,
    localparam int ID_W      = $clog2(NUM_STOCKS),
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    execution_dispatcher_if.slave       bus,
    input  logic [ID_W-1:0]             i_query_stock_id,
    output logic signed [POS_WIDTH-1:0] o_position,
    output logic [CW-1:0]               o_fifo_count,
    output logic [NUM_STOCKS-1:0]       o_limit_flag,
    input  logic [POS_WIDTH-1:0]        i_max_position
);
    typedef struct packed {
        logic            side;
        logic [15:0]     qty;
        logic [ID_W-1:0] id;
    } fill_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    localparam int EW = ((POS_WIDTH > 16) ? POS_WIDTH : 16) + 2;
    localparam logic signed [EW-1:0] POS_MAX = {{(EW-POS_WIDTH+1){1'b0}}, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] POS_MIN = {{(EW-POS_WIDTH+1){1'b1}}, {(POS_WIDTH-1){1'b0}}};

    state_t                      r_state, w_state_nxt;
    fill_t                       r_mem [FIFO_DEPTH];
    logic [AW-1:0]               r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]               r_count;
    fill_t                       r_out;
    logic signed [POS_WIDTH-1:0] r_position [NUM_STOCKS];

    logic                        w_fill_ready, w_push, w_pop, w_avail;
    fill_t                       w_in, w_head;
    logic signed [POS_WIDTH-1:0] w_cur;
    logic signed [EW-1:0]        w_pos_ext, w_delta, w_sum;
    logic signed [POS_WIDTH-1:0] w_pos_nxt;

    assign w_fill_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push       = bus.i_fill_valid & w_fill_ready & (bus.i_fill_quantity != 16'd0);
    assign w_avail      = (r_count != '0) | w_push;
    assign w_in         = '{side: bus.i_fill_side, qty: bus.i_fill_quantity, id: bus.i_fill_stock_id};
    // An empty FIFO forwards the incoming fill so it can strobe the very next cycle.
    assign w_head       = (r_count != '0) ? r_mem[r_rd_ptr] : w_in;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ISSUE: begin
                if (!w_avail)       w_state_nxt = S_IDLE;
                else if (bus.i_hold) w_state_nxt = S_HOLD;
                else                w_state_nxt = S_ISSUE;
            end
            S_HOLD:  if (!bus.i_hold) w_state_nxt = S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop                        = (w_state_nxt == S_ISSUE);
        bus.o_execute_order          = (r_state == S_ISSUE);
        bus.o_execute_order_side     = r_out.side;
        bus.o_execute_order_quantity = r_out.qty;
        bus.o_stock_id               = r_out.id;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_out    <= w_head;
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Wide intermediate so a full 16-bit quantity can never wrap before clamping.
    always_comb begin
        w_cur     = r_position[r_out.id];
        w_pos_ext = {{(EW-POS_WIDTH){w_cur[POS_WIDTH-1]}}, w_cur};
        w_delta   = {{(EW-16){1'b0}}, r_out.qty};
        w_sum     = r_out.side ? (w_pos_ext - w_delta) : (w_pos_ext + w_delta);
        if (w_sum > POS_MAX)      w_pos_nxt = POS_MAX[POS_WIDTH-1:0];
        else if (w_sum < POS_MIN) w_pos_nxt = POS_MIN[POS_WIDTH-1:0];
        else                      w_pos_nxt = w_sum[POS_WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int s = 0; s < NUM_STOCKS; s++) r_position[s] <= '0;
        end else if (r_state == S_ISSUE) begin
            r_position[r_out.id] <= w_pos_nxt;
        end
    end

    assign o_position   = r_position[i_query_stock_id];
    assign o_fifo_count = r_count;
    assign bus.o_fill_ready = w_fill_ready;

`ifdef POS_LIMIT_EN
    logic [NUM_STOCKS-1:0] r_limit_flag;
    logic [POS_WIDTH-1:0]  w_abs [NUM_STOCKS];

    always_comb begin
        for (int s = 0; s < NUM_STOCKS; s++)
            w_abs[s] = r_position[s][POS_WIDTH-1] ? POS_WIDTH'(-r_position[s]) : r_position[s];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_limit_flag <= '0;
        end else begin
            for (int s = 0; s < NUM_STOCKS; s++)
                r_limit_flag[s] <= (w_abs[s] >= i_max_position);
        end
    end

    assign o_limit_flag = r_limit_flag;
`else
    logic w_unused_max;
    assign w_unused_max = ^i_max_position;
    assign o_limit_flag = '0;
`endif
endmodule

// File: tb/tb_execution_dispatcher.sv
// Scoreboard bench: stimulus pushes expected strobes into a queue, a negedge monitor pops and compares.
module tb_execution_dispatcher;
    localparam int NS    = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           query_id = '0;
    logic signed [PW-1:0] position;
    logic [3:0]           fifo_count;
    logic [NS-1:0]        limit_flag;
    logic [PW-1:0]        max_pos = 16'd500;
    bit                   query_rand = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execution_dispatcher_if #(.ID_W(2)) bus ();

    execution_dispatcher #(.NUM_STOCKS(NS), .FIFO_DEPTH(DEPTH), .POS_WIDTH(PW)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .bus              (bus),
        .i_query_stock_id (query_id),
        .o_position       (position),
        .o_fifo_count     (fifo_count),
        .o_limit_flag     (limit_flag),
        .i_max_position   (max_pos)
    );

    typedef struct {
        bit side;
        int qty;
        int id;
    } fill_s;

    fill_s         exp_q[$];
    longint        mpos[NS];
    bit            exp_strobe = 1'b0;
    bit [NS-1:0]   exp_flag   = '0;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: strobe when work is queued and the previous cycle was not held or in reset.
    always @(negedge clk) begin
        fill_s       f;
        bit [NS-1:0] nf;
        longint      v;
        check("strobe", bus.o_execute_order, exp_strobe);
        check("position", position, mpos[query_id]);
        check("limit_flag", limit_flag, exp_flag);
        nf = '0;
`ifdef POS_LIMIT_EN
        for (int s = 0; s < NS; s++)
            nf[s] = ((mpos[s] < 0) ? -mpos[s] : mpos[s]) >= longint'(max_pos);
`endif
        exp_flag = rst_n ? nf : '0;
        if (bus.o_execute_order) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got strobe id %0d qty %0d, expected none",
                         bus.o_stock_id, bus.o_execute_order_quantity);
            end else begin
                f = exp_q.pop_front();
                check("strobe_side", bus.o_execute_order_side, f.side);
                check("strobe_qty", bus.o_execute_order_quantity, f.qty);
                check("strobe_id", bus.o_stock_id, f.id);
                v = mpos[f.id] + (f.side ? -longint'(f.qty) : longint'(f.qty));
                if (v > 32767)  v = 32767;
                if (v < -32768) v = -32768;
                mpos[f.id] = v;
            end
        end
        check("fifo_count", fifo_count, exp_q.size());
        check("fill_ready", bus.o_fill_ready, exp_q.size() < DEPTH);
        if (bus.i_fill_valid && bus.o_fill_ready && bus.i_fill_quantity != 0)
            exp_q.push_back('{side: bus.i_fill_side, qty: int'(bus.i_fill_quantity),
                              id: int'(bus.i_fill_stock_id)});
        if (!rst_n) begin
            exp_q.delete();
            for (int s = 0; s < NS; s++) mpos[s] = 0;
        end
        exp_strobe = rst_n && !bus.i_hold && (exp_q.size() > 0);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (query_rand) query_id = 2'($urandom_range(0, NS - 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit side, input int id, input int qty);
        bit acc;
        int n;
        bus.i_fill_valid    = 1'b1;
        bus.i_fill_side     = side;
        bus.i_fill_stock_id = 2'(id);
        bus.i_fill_quantity = 16'(qty);
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.o_fill_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 0, 1);
        bus.i_fill_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bus.i_fill_valid    = 1'b0;
        bus.i_fill_side     = 1'b0;
        bus.i_fill_stock_id = '0;
        bus.i_fill_quantity = '0;
        bus.i_hold          = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // single buy
        query_rand = 1'b0;
        query_id   = 2'd1;
        send(1'b0, 1, 100);
        idle(3);

        // burst into a held FIFO, then an extra attempt while full
        bus.i_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(i[0], i % NS, 10 + i);
        bus.i_fill_valid    = 1'b1;
        bus.i_fill_quantity = 16'd77;
        idle(1);
        bus.i_fill_valid = 1'b0;
        idle(4);
        bus.i_hold = 1'b0;
        idle(12);

        // saturation both ways
        query_id = 2'd2;
        send(1'b1, 2, 40000);
        send(1'b1, 2, 40000);
        idle(3);
        query_id = 2'd3;
        send(1'b0, 3, 40000);
        send(1'b0, 3, 40000);
        idle(3);

        // zero quantity is accepted but ignored
        send(1'b0, 0, 0);
        idle(3);

        // reset with three queued fills
        bus.i_hold = 1'b1;
        send(1'b0, 1, 5);
        send(1'b1, 2, 6);
        send(1'b0, 3, 7);
        rst_n = 1'b0;
        idle(2);
        bus.i_hold = 1'b0;
        rst_n = 1'b1;
        idle(3);

        // limit threshold on stock 0
        query_id = 2'd0;
        send(1'b0, 0, 300);
        send(1'b0, 0, 300);
        idle(3);

        // randomized traffic
        query_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.i_fill_valid    = ($urandom_range(0, 2) != 0);
            bus.i_fill_side     = 1'($urandom_range(0, 1));
            bus.i_fill_stock_id = 2'($urandom_range(0, NS - 1));
            r = $urandom_range(0, 7);
            if (r == 0)      bus.i_fill_quantity = 16'd0;
            else if (r == 1) bus.i_fill_quantity = 16'($urandom_range(30000, 65535));
            else             bus.i_fill_quantity = 16'($urandom_range(1, 1000));
            bus.i_hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                bus.i_fill_valid = 1'b0;
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) max_pos = 16'($urandom_range(0, 40000));
            idle(1);
        end
        bus.i_fill_valid = 1'b0;
        bus.i_hold       = 1'b0;
        rst_n            = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
        idle(2);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
